// File: rtl/memory_controller_pkg.sv
// Shared encodings for the memory controller: FSM states, access sizes, IO window prefix.
package memory_controller_pkg;

    localparam int CNT_W = 7;  // holds a beat count up to 64

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IFETCH = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] IO_PREFIX = 2'b11;

    // Size code 3 is treated as a word.
    function automatic logic [CNT_W-1:0] size_beats(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 7'd1;
            SZ_HALF: return 7'd2;
            default: return 7'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_beat_counter.sv
// Beat sequencer: counts beats of one access and owns the byte address driven onto the RAM.
module mem_beat_counter
    import memory_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      base,
    input  logic [CNT_W-1:0] beats,
    input  logic             step,
    input  logic             addr_step,
    output logic [31:0]      addr,
    output logic [CNT_W-1:0] cnt,
    output logic             last_beat,
    output logic             all_beats
);

    logic [CNT_W-1:0] n;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
            n    <= '0;
        end else if (load) begin
            addr <= base;
            cnt  <= '0;
            n    <= beats;
        end else begin
            if (step)      cnt  <= cnt + 1'b1;
            if (addr_step) addr <= addr + 32'd1;  // wraps modulo 2^32
        end
    end

    assign last_beat = (cnt == n - 1'b1);
    assign all_beats = (cnt == n);

endmodule

// File: rtl/memory_controller.sv
// Byte-wide RAM/IO port owner: arbitrates icache refills vs LSB accesses and sequences byte beats.
// Optional macro MEM_CTRL_RR_EN selects round-robin arbitration; default is LSB-first priority.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_rst,
    input  logic                    icache_req,
    input  logic [ADDR_W-1:0]       icache_addr,
    output logic                    icache_ack,
    output logic [8*LINE_BYTES-1:0] icache_line,
    input  logic                    lsb_req,
    input  logic                    lsb_wr,
    input  logic [1:0]              lsb_size,
    input  logic [31:0]             lsb_addr,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    logic [2:0]       state;
    logic             is_io;
    logic [23:0]      wbuf;
    logic             ic_ok, grant_ic, grant_lsb, grant_io, ld;
    logic             step, addr_step;
    logic [31:0]      base;
    logic [CNT_W-1:0] beats, cnt;
    logic             last_beat, all_beats;
    logic [1:0]       rd_idx;
`ifdef MEM_CTRL_RR_EN
    logic             last_grant;  // 0 = icache served last, 1 = LSB
`endif

    always_comb begin
        ic_ok = icache_req && !pc_rst;
`ifdef MEM_CTRL_RR_EN
        grant_lsb = (state == S_IDLE) && lsb_req && (!ic_ok || !last_grant);
`else
        grant_lsb = (state == S_IDLE) && lsb_req;
`endif
        grant_ic = (state == S_IDLE) && ic_ok && !grant_lsb;
        ld       = grant_ic || grant_lsb;
        grant_io = (lsb_addr[17:16] == IO_PREFIX);
        base     = grant_lsb ? lsb_addr : 32'(icache_addr);
        beats    = grant_lsb ? size_beats(lsb_size) : CNT_W'(LINE_BYTES);
    end

    // Reads keep counting one beat past the last address to catch the trailing byte.
    always_comb begin
        step      = 1'b0;
        addr_step = 1'b0;
        case (state)
            S_IFETCH, S_LOAD: begin
                if (!(state == S_IFETCH && pc_rst)) begin
                    step      = !all_beats;
                    addr_step = !all_beats && !last_beat;
                end
            end
            S_STORE: begin
                step      = mem_wr && !last_beat;
                addr_step = mem_wr && !last_beat;
            end
            default: ;
        endcase
    end

    mem_beat_counter u_beats (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .base      (base),
        .beats     (beats),
        .step      (step),
        .addr_step (addr_step),
        .addr      (mem_a),
        .cnt       (cnt),
        .last_beat (last_beat),
        .all_beats (all_beats)
    );

    assign rd_idx = 2'(cnt - 1'b1);

`ifdef MEM_CTRL_RR_EN
    always_ff @(posedge clk) begin
        if (rst)     last_grant <= 1'b0;
        else if (ld) last_grant <= grant_lsb;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_wr      <= 1'b0;
            mem_dout    <= '0;
            icache_ack  <= 1'b0;
            lsb_done    <= 1'b0;
            icache_line <= '0;
            lsb_rdata   <= '0;
            wbuf        <= '0;
            is_io       <= 1'b0;
        end else begin
            icache_ack <= 1'b0;
            lsb_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_lsb) begin
                        state     <= lsb_wr ? S_STORE : S_LOAD;
                        is_io     <= grant_io;
                        mem_wr    <= lsb_wr && !(grant_io && io_buffer_full);
                        mem_dout  <= lsb_wdata[7:0];
                        wbuf      <= lsb_wdata[31:8];
                        lsb_rdata <= '0;
                    end else if (grant_ic) begin
                        state <= S_IFETCH;
                    end
                end
                S_IFETCH: begin
                    if (pc_rst) begin
                        state <= S_IDLE;
                    end else begin
                        if (cnt != '0) icache_line <= {mem_din, icache_line[8*LINE_BYTES-1:8]};
                        if (all_beats) begin
                            icache_ack <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt != '0) lsb_rdata[{rd_idx, 3'b000} +: 8] <= mem_din;
                    if (all_beats) begin
                        lsb_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_STORE: begin
                    // A cycle with mem_wr low is a stalled IO beat; it is retried, not advanced.
                    if (mem_wr && last_beat) begin
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        if (mem_wr) begin
                            mem_dout <= wbuf[7:0];
                            wbuf     <= {8'h00, wbuf[23:8]};
                        end
                        mem_wr <= !(is_io && io_buffer_full);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: refill, load, store, IO stall, flush and arbitration.
module tb_memory_controller;

    logic         clk = 1'b0;
    logic         rst, pc_rst;
    logic         icache_req;
    logic [16:0]  icache_addr;
    logic         icache_ack;
    logic [127:0] icache_line;
    logic         lsb_req, lsb_wr;
    logic [1:0]   lsb_size;
    logic [31:0]  lsb_addr, lsb_wdata;
    logic         lsb_done;
    logic [31:0]  lsb_rdata;
    logic [7:0]   mem_din, mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full;

    logic [7:0]   ram [0:4095];
    int           io_wr_cnt;
    logic [7:0]   io_byte;
    int           total = 0;
    int           bad   = 0;

    memory_controller dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ack(icache_ack), .icache_line(icache_line),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        case (a)
            'h203:   return 8'h11;
            'h204:   return 8'h22;
            'h205:   return 8'h33;
            'h206:   return 8'h44;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    // RAM with one-cycle read latency; the IO window is logged separately.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
            io_wr_cnt <= 0;
            io_byte   <= '0;
        end else if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_wr_cnt <= io_wr_cnt + 1;
                io_byte   <= mem_dout;
            end else begin
                ram[mem_a[11:0]] <= mem_dout;
            end
        end
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_at(input int base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = pat(base + i);
        return l;
    endfunction

    initial begin
        int io0;
        rst = 1'b1; pc_rst = 1'b0; icache_req = 1'b0; icache_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        repeat (3) step();
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_ack", icache_ack, 0);
        chk("rst_done", lsb_done, 0);
        rst = 1'b0;
        step();

        // icache refill of line 0x100
        icache_req = 1'b1; icache_addr = 17'h00100;
        step();
        for (int k = 0; k < 16; k++) begin
            chk("if_addr", mem_a, 128'(32'h100 + k));
            chk("if_noack", icache_ack, 0);
            step();
        end
        chk("if_noack16", icache_ack, 0);
        step();
        chk("if_ack17", icache_ack, 1);
        chk("if_line", icache_line, line_at('h100));
        icache_req = 1'b0;
        step();
        chk("if_ack_pulse", icache_ack, 0);
        step();

        // word load at unaligned 0x203
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h203;
        step();
        chk("ld_addr0", mem_a, 32'h203);
        chk("ld_nowr", mem_wr, 0);
        step(); step(); step();
        chk("ld_addr3", mem_a, 32'h206);
        step();
        chk("ld_nodone4", lsb_done, 0);
        step();
        chk("ld_done5", lsb_done, 1);
        chk("ld_rdata", lsb_rdata, 32'h44332211);
        lsb_req = 1'b0;
        step();
        chk("ld_done_pulse", lsb_done, 0);

        // half store 0xBEEF at 0x300
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h300; lsb_wdata = 32'h0000BEEF;
        step();
        chk("st_wr0", mem_wr, 1);
        chk("st_dout0", mem_dout, 8'hEF);
        chk("st_addr0", mem_a, 32'h300);
        step();
        chk("st_wr1", mem_wr, 1);
        chk("st_dout1", mem_dout, 8'hBE);
        chk("st_addr1", mem_a, 32'h301);
        chk("st_nodone1", lsb_done, 0);
        step();
        chk("st_wr_off", mem_wr, 0);
        chk("st_done2", lsb_done, 1);
        chk("st_ram300", ram[12'h300], 8'hEF);
        chk("st_ram301", ram[12'h301], 8'hBE);
        lsb_req = 1'b0;
        step();

        // IO byte store with the sink full for three cycles
        io0 = io_wr_cnt;
        io_buffer_full = 1'b1;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h5A;
        step();
        chk("io_stall0", mem_wr, 0);
        step();
        chk("io_stall1", mem_wr, 0);
        step();
        chk("io_stall2", mem_wr, 0);
        io_buffer_full = 1'b0;
        step();
        chk("io_wr3", mem_wr, 1);
        chk("io_dout3", mem_dout, 8'h5A);
        chk("io_nodone3", lsb_done, 0);
        chk("io_none_yet", io_wr_cnt, io0);
        step();
        chk("io_done4", lsb_done, 1);
        chk("io_wr_off", mem_wr, 0);
        chk("io_one_write", io_wr_cnt, io0 + 1);
        chk("io_byte", io_byte, 8'h5A);
        lsb_req = 1'b0;
        step();

        // flush a refill mid-line, then refetch from 0x0
        icache_req = 1'b1; icache_addr = 17'h00080;
        step();
        chk("fl_addr0", mem_a, 32'h80);
        repeat (6) step();
        chk("fl_addr6", mem_a, 32'h86);
        pc_rst = 1'b1; icache_addr = 17'h0;
        step();
        chk("fl_noack", icache_ack, 0);
        chk("fl_addr_hold", mem_a, 32'h86);
        step();
        chk("fl_idle_nogrant", mem_a, 32'h86);
        pc_rst = 1'b0;
        step();
        chk("fl_fresh_addr0", mem_a, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("fl_noack_beats", icache_ack, 0);
        end
        step();
        chk("fl_ack17", icache_ack, 1);
        chk("fl_line", icache_line, line_at(0));
        icache_req = 1'b0;
        step(); step();

        // simultaneous requests, twice back-to-back
        icache_req = 1'b1; icache_addr = 17'h00100;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h205;
        step();
        chk("arb1_lsb", mem_a, 32'h205);
        step(); step();
        chk("arb1_done", lsb_done, 1);
        chk("arb1_rdata", lsb_rdata, 32'h33);
        lsb_addr = 32'h206;
        step(); step();
`ifdef MEM_CTRL_RR_EN
        chk("arb2_icache", mem_a, 32'h100);
        lsb_req = 1'b0;
        repeat (17) step();
        chk("arb2_ack", icache_ack, 1);
        chk("arb2_line", icache_line, line_at('h100));
`else
        chk("arb2_lsb", mem_a, 32'h206);
        icache_req = 1'b0;
        step(); step();
        chk("arb2_done", lsb_done, 1);
        chk("arb2_rdata", lsb_rdata, 32'h44);
`endif
        icache_req = 1'b0; lsb_req = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
